// File: rtl/adsr_voice_if.sv
// Event and voice-control bundle between the note front end, the allocator and
// the per-voice ADSR datapath.
//   master : event source / envelope side (drives events and release_done)
//   slave  : allocator (drives on_ready, gate, trig, voice_note, voice_busy,
//            steal, off_miss)
interface adsr_voice_if #(
  parameter int unsigned NV     = 4,
  parameter int unsigned NOTE_W = 8
);
  logic                 on_valid;
  logic [NOTE_W-1:0]    on_note;
  logic                 on_ready;
  logic                 off_valid;
  logic [NOTE_W-1:0]    off_note;
  logic [NV-1:0]        release_done;
  logic [NV-1:0]        gate;
  logic [NV-1:0]        trig;
  logic [NV*NOTE_W-1:0] voice_note;
  logic [NV-1:0]        voice_busy;
  logic                 steal;
  logic                 off_miss;

  modport master (
    output on_valid, on_note, off_valid, off_note, release_done,
    input  on_ready, gate, trig, voice_note, voice_busy, steal, off_miss
  );

  modport slave (
    input  on_valid, on_note, off_valid, off_note, release_done,
    output on_ready, gate, trig, voice_note, voice_busy, steal, off_miss
  );
endinterface

// File: rtl/adsr_voice_allocator.sv
// Polyphonic voice allocator: maps note-on/note-off events onto NV ADSR voices,
// drives per-voice gate and retrigger strobes, and steals the least-recently
// used voice when none is free.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : adsr_voice_if.slave (events in, voice control out)
module adsr_voice_allocator #(
  parameter int unsigned NV     = 4,
  parameter int unsigned NOTE_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  adsr_voice_if.slave   bus
);

  localparam int unsigned RW = (NV > 1) ? $clog2(NV) : 1;

  typedef logic [RW-1:0]     rank_t;
  typedef logic [NOTE_W-1:0] note_t;
  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_HELD = 2'd1,
    V_REL  = 2'd2
  } voice_state_e;

  voice_state_e  state_q [NV];
  voice_state_e  state_d [NV];
  note_t         note_q  [NV];
  note_t         note_d  [NV];
  rank_t         rank_q  [NV];
  rank_t         rank_d  [NV];

  logic [NV-1:0] gate_q, gate_d;
  logic [NV-1:0] trig_q, trig_d;
  logic [NV-1:0] busy_q, busy_d;
  logic          steal_q, steal_d;
  logic          off_miss_q, off_miss_d;

  logic          on_accept_c;

  // Off events take the cycle; the note-on source holds its event.
  assign bus.on_ready = !reset && !bus.off_valid;
  assign on_accept_c  = bus.on_valid && !reset && !bus.off_valid;

  // Voice search results
  logic  hit_found, idle_found, rel_found, off_found;
  rank_t hit_v, idle_v, rel_v, old_v, off_v, pick_v;
  rank_t rel_rank;

  // Search the current voice table for allocation and note-off candidates.
  always_comb begin
    hit_found  = 1'b0;
    idle_found = 1'b0;
    rel_found  = 1'b0;
    off_found  = 1'b0;
    hit_v      = '0;
    idle_v     = '0;
    rel_v      = '0;
    old_v      = '0;
    off_v      = '0;
    rel_rank   = '0;
    for (int i = 0; i < NV; i++) begin
      if (!hit_found && state_q[i] == V_HELD && note_q[i] == bus.on_note) begin
        hit_found = 1'b1;
        hit_v     = RW'(i);
      end
      if (!idle_found && state_q[i] == V_IDLE) begin
        idle_found = 1'b1;
        idle_v     = RW'(i);
      end
      // Releasing voice with the oldest rank; ranks are unique so no tie.
      if (state_q[i] == V_REL && (!rel_found || rank_q[i] < rel_rank)) begin
        rel_found = 1'b1;
        rel_v     = RW'(i);
        rel_rank  = rank_q[i];
      end
      if (rank_q[i] == '0) begin
        old_v = RW'(i);
      end
      if (!off_found && state_q[i] == V_HELD && note_q[i] == bus.off_note) begin
        off_found = 1'b1;
        off_v     = RW'(i);
      end
    end
    if (hit_found) begin
      pick_v = hit_v;
    end else if (idle_found) begin
      pick_v = idle_v;
    end else if (rel_found) begin
      pick_v = rel_v;
    end else begin
      pick_v = old_v;
    end
  end

  // Next-state: release completion first, then the single event of the cycle
  // so that an allocation overrides release_done on the same voice.
  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    rank_d     = rank_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    off_miss_d = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (state_q[i] == V_REL && bus.release_done[i]) begin
        state_d[i] = V_IDLE;
      end
    end

    if (bus.off_valid) begin
      if (off_found) begin
        state_d[off_v] = V_REL;
      end else begin
        off_miss_d = 1'b1;
      end
    end else if (on_accept_c) begin
      state_d[pick_v] = V_HELD;
      note_d[pick_v]  = bus.on_note;
      trig_d[pick_v]  = 1'b1;
      steal_d         = !hit_found && !idle_found;
      // Age every voice newer than the chosen one, then make it the newest.
      for (int j = 0; j < NV; j++) begin
        if (rank_q[j] > rank_q[pick_v]) begin
          rank_d[j] = rank_q[j] - rank_t'(1);
        end
      end
      rank_d[pick_v] = RW'(NV - 1);
    end

    for (int i = 0; i < NV; i++) begin
      gate_d[i] = (state_d[i] == V_HELD);
      busy_d[i] = (state_d[i] != V_IDLE);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NV; i++) begin
        state_q[i] <= V_IDLE;
        note_q[i]  <= '0;
        rank_q[i]  <= RW'(i);
      end
      gate_q     <= '0;
      trig_q     <= '0;
      busy_q     <= '0;
      steal_q    <= 1'b0;
      off_miss_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      rank_q     <= rank_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      steal_q    <= steal_d;
      off_miss_q <= off_miss_d;
    end
  end

  assign bus.gate       = gate_q;
  assign bus.trig       = trig_q;
  assign bus.voice_busy = busy_q;
  assign bus.steal      = steal_q;
  assign bus.off_miss   = off_miss_q;

  // Flatten the per-voice note table onto the output bus.
  for (genvar g = 0; g < NV; g++) begin : g_note
    assign bus.voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
  end

endmodule

// File: tb/tb_adsr_voice_allocator.sv
// Directed self-checking bench for adsr_voice_allocator (NV=4, NOTE_W=8).
module tb_adsr_voice_allocator;

  localparam int unsigned NV     = 4;
  localparam int unsigned NOTE_W = 8;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  adsr_voice_if #(.NV(NV), .NOTE_W(NOTE_W)) bus ();

  adsr_voice_allocator #(.NV(NV), .NOTE_W(NOTE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gate, trig, busy, steal, off_miss in one call
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] t,
                         input logic [3:0] b, input logic s, input logic m);
    chk({tag, ".gate"},     32'(bus.gate),       32'(g));
    chk({tag, ".trig"},     32'(bus.trig),       32'(t));
    chk({tag, ".busy"},     32'(bus.voice_busy), 32'(b));
    chk({tag, ".steal"},    32'(bus.steal),      32'(s));
    chk({tag, ".off_miss"}, 32'(bus.off_miss),   32'(m));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_on(input logic [7:0] n);
    bus.on_valid = 1'b1;
    bus.on_note  = n;
    tick();
    bus.on_valid = 1'b0;
  endtask

  task automatic note_off(input logic [7:0] n);
    bus.off_valid = 1'b1;
    bus.off_note  = n;
    tick();
    bus.off_valid = 1'b0;
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.on_valid     = 1'b0;
    bus.on_note      = '0;
    bus.off_valid    = 1'b0;
    bus.off_note     = '0;
    bus.release_done = '0;

    tick();
    tick();
    chk_out("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("reset.vnote", bus.voice_note, 32'h0);
    chk("reset.on_ready", 32'(bus.on_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle.on_ready", 32'(bus.on_ready), 32'd1);

    // Fill three voices in consecutive cycles
    note_on(8'd60);
    chk_out("on60", 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    note_on(8'd62);
    chk_out("on62", 4'b0011, 4'b0010, 4'b0011, 1'b0, 1'b0);
    note_on(8'd64);
    chk_out("on64", 4'b0111, 4'b0100, 4'b0111, 1'b0, 1'b0);
    chk("on64.vnote", bus.voice_note, 32'h00_40_3E_3C);
    tick();
    chk("quiet.trig", 32'(bus.trig), 32'd0);

    // Fourth voice, then steal the oldest held voice (voice 0)
    note_on(8'd65);
    chk_out("on65", 4'b1111, 4'b1000, 4'b1111, 1'b0, 1'b0);
    note_on(8'd67);
    chk_out("on67.steal", 4'b1111, 4'b0001, 4'b1111, 1'b1, 1'b0);
    chk("on67.vnote", bus.voice_note, 32'h41_40_3E_43);

    // Releasing voice is preferred over older held voices
    note_off(8'd62);
    chk_out("off62", 4'b1101, 4'b0000, 4'b1111, 1'b0, 1'b0);
    note_on(8'd69);
    chk_out("on69.steal_rel", 4'b1111, 4'b0010, 4'b1111, 1'b1, 1'b0);
    chk("on69.vnote", bus.voice_note, 32'h41_40_45_43);

    // Two releasing voices: lowest rank (voice 3) wins over lower index (voice 0)
    note_off(8'd67);
    chk_out("off67", 4'b1110, 4'b0000, 4'b1111, 1'b0, 1'b0);
    note_off(8'd65);
    chk_out("off65", 4'b0110, 4'b0000, 4'b1111, 1'b0, 1'b0);
    note_on(8'd70);
    chk_out("on70.rank", 4'b1110, 4'b1000, 4'b1111, 1'b1, 1'b0);
    chk("on70.vnote", bus.voice_note, 32'h46_40_45_43);

    // Simultaneous off and on: off wins, on waits one cycle
    bus.off_valid = 1'b1;
    bus.off_note  = 8'd99;
    bus.on_valid  = 1'b1;
    bus.on_note   = 8'd72;
    #1;
    chk("both.on_ready", 32'(bus.on_ready), 32'd0);
    tick();
    chk_out("off99.miss", 4'b1110, 4'b0000, 4'b1111, 1'b0, 1'b1);
    bus.off_valid = 1'b0;
    #1;
    chk("held_on.on_ready", 32'(bus.on_ready), 32'd1);
    tick();
    bus.on_valid = 1'b0;
    chk_out("on72.late", 4'b1111, 4'b0001, 4'b1111, 1'b1, 1'b0);
    chk("on72.vnote", bus.voice_note, 32'h46_40_45_48);

    // Reset restores idle table
    reset = 1'b1;
    #1;
    chk("rst.on_ready", 32'(bus.on_ready), 32'd0);
    tick();
    reset = 1'b0;
    chk_out("rst2", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rst2.vnote", bus.voice_note, 32'h0);

    // Same note twice retriggers one voice; release_done while held ignored
    note_on(8'd60);
    chk_out("re60a", 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    note_on(8'd60);
    chk_out("re60b", 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    bus.release_done = 4'b0001;
    tick();
    chk_out("rd_held", 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
    bus.release_done = 4'b0000;
    note_off(8'd60);
    chk_out("off60", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
    note_off(8'd60);
    chk_out("off60.rel_nomatch", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1);
    bus.release_done = 4'b0001;
    tick();
    bus.release_done = 4'b0000;
    chk_out("rd_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rd_idle.vnote", bus.voice_note, 32'h00_00_00_3C);

    // Fill all four; voice 0 is oldest
    note_on(8'd61);
    note_on(8'd62);
    note_on(8'd63);
    note_on(8'd64);
    chk_out("fill", 4'b1111, 4'b1000, 4'b1111, 1'b0, 1'b0);
    chk("fill.vnote", bus.voice_note, 32'h40_3F_3E_3D);

    // Allocation beats release_done on the same voice
    note_off(8'd61);
    bus.release_done = 4'b0001;
    note_on(8'd66);
    bus.release_done = 4'b0000;
    chk_out("alloc_wins", 4'b1111, 4'b0001, 4'b1111, 1'b1, 1'b0);

    // release_done on an untouched voice lands in the same cycle as the event
    note_off(8'd62);
    note_off(8'd63);
    chk_out("off62_63", 4'b1001, 4'b0000, 4'b1111, 1'b0, 1'b0);
    bus.release_done = 4'b0100;
    note_on(8'd67);
    bus.release_done = 4'b0000;
    chk_out("rd_side", 4'b1011, 4'b0010, 4'b1011, 1'b1, 1'b0);
    chk("rd_side.vnote", bus.voice_note, 32'h40_3F_43_42);

    // Reset with three voices held and a note-on pending
    bus.on_valid = 1'b1;
    bus.on_note  = 8'd70;
    reset        = 1'b1;
    #1;
    chk("rst3.on_ready", 32'(bus.on_ready), 32'd0);
    tick();
    bus.on_valid = 1'b0;
    reset        = 1'b0;
    chk_out("rst3", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rst3.vnote", bus.voice_note, 32'h0);

    // Ranks back to 0..3: four fills then a steal of voice 0
    for (int i = 0; i < 4; i++) begin
      note_on(8'(80 + i));
      chk("refill.trig", 32'(bus.trig), 32'(1 << i));
    end
    note_on(8'd84);
    chk_out("rank_reset.steal", 4'b1111, 4'b0001, 4'b1111, 1'b1, 1'b0);
    chk("rank_reset.vnote", bus.voice_note, 32'h53_52_51_54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_voice_allocator.md
# adsr_voice_allocator

Polyphonic voice allocator that sequences a bank of NV ADSR envelope engines from a stream of note-on/note-off events. It picks a voice for each note, drives that voice's gate and retrigger strobe, tracks each voice through held, releasing and idle, and steals the least-recently-used voice when all are busy. It sits between the key/event front end and the per-voice ADSR + waveform modulation datapath.

## Interface
- NV, 4: number of voices (2..8).
- NOTE_W, 8: note code width.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- on_valid  in  1  note-on event present.
- on_note  in  NOTE_W  note code for note-on.
- on_ready  out  1  note-on accepted this cycle when on_valid && on_ready; combinational = !reset && !off_valid.
- off_valid  in  1  note-off event present; always accepted (no ready).
- off_note  in  NOTE_W  note code for note-off.
- release_done  in  NV  per-voice level from ADSR: envelope reached 0 in release.
- gate  out  NV  per-voice gate, registered.
- trig  out  NV  per-voice one-cycle retrigger strobe, registered.
- voice_note  out  NV*NOTE_W  note assigned to each voice, voice i at [i*NOTE_W +: NOTE_W].
- voice_busy  out  NV  voice state != IDLE.
- steal  out  1  one-cycle pulse: last accepted note-on stole a busy voice.
- off_miss  out  1  one-cycle pulse: note-off matched no held voice.

## Operation
- Per-voice state: IDLE, HELD, RELEASING. gate[i] = (state == HELD).
- Per-voice LRU rank, clog2(NV) bits, ranks always a permutation of 0..NV-1; 0 = oldest, NV-1 = newest.
- One event per cycle; off_valid has priority (on_ready low that cycle, note-on source holds its event).
- Note-on accepted, decision on current registered state, in priority order:
  - a HELD voice already has on_note: retrigger it (lowest index if several): trig pulse, stays HELD, no steal.
  - any IDLE voice: take lowest-index IDLE.
  - any RELEASING voice: steal the RELEASING voice with lowest rank; steal=1.
  - else steal voice with rank 0 (oldest HELD); steal=1.
  - Chosen voice v: state HELD, voice_note[v] = on_note, trig[v]=1 one cycle, rank[v] = NV-1, every voice with rank > old rank[v] decrements.
- Note-off: lowest-index HELD voice whose voice_note == off_note goes RELEASING (gate falls); ranks unchanged. No match: off_miss=1, no state change. RELEASING voices never match.
- release_done[i] while RELEASING: go IDLE (voice_note retained). Ignored in IDLE or HELD.
- Same cycle, same voice chosen for allocation and release_done[v]=1: allocation wins (HELD).
- release_done on voices not touched by the event applies in the same cycle as the event.

## Timing
- Reset (sync): all states IDLE, gate=0, trig=0, voice_note=0, steal=0, off_miss=0, rank[i]=i; on_ready=0 while reset high.
- Reset mid-note: next edge with reset high forces reset values; pending trig dropped.
- Latency: event accepted at edge k -> gate/trig/voice_note/steal/off_miss valid after edge k (1 cycle).
- trig, steal, off_miss are single-cycle; back-to-back events give back-to-back pulses.
- Retrigger of a stolen or same-note HELD voice keeps gate high continuously; only trig marks the restart.
- Throughput: one event per cycle; note-on sustained at 1/cycle when off_valid low.

## Test plan
- Reset then note-ons 60,62,64 on consecutive cycles -> voices 0,1,2 gate=1, one trig each, voice_note 60/62/64, steal=0, voice_busy=0111.
- Fill 4 voices (60,62,64,65), note-on 67 -> voice 0 (rank 0) stolen: trig[0]=1, voice_note[0]=67, steal=1, gate stays 1111.
- 4 held, note-off 62 then note-on 69 -> voice 1 RELEASING then stolen before others (RELEASING preferred), steal=1.
- off_valid and on_valid together -> off processed, on_ready=0 that cycle, note-on accepted next cycle; note-off 99 unmatched -> off_miss=1 only.
- Note-on 60 twice -> same voice retriggered, two trig pulses, only one voice busy; release_done[0] while HELD ignored; after note-off and release_done[0]=1 -> voice_busy[0]=0.
- Reset asserted while 3 voices HELD -> next cycle gate=0, voice_busy=0, ranks 0..3, on_ready=0 during reset.
